alu_serial_ctrl: RTL

Bit-serial 32-bit ALU sequencer. It sequences a single 1-bit ALU slice across 32 bit positions, one bit per clock, and holds the inter-bit carry in a flip-flop. It assembles the 32-bit result in a shift register and handles the SLT fix-up pass. It sits between the control unit and the register file as a low-area alternative to the 32-slice ripple ALU, with a start/done handshake.

---
 rtl/alu_serial_if.sv | 31 +++
 rtl/alu_serial_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_serial_if.sv
// Handshake and operand/result bundle between the control unit and the
// bit-serial ALU sequencer.
//   start    : request, honoured only while the sequencer is idle
//   op       : operation code (AND/OR/ADD/SUB/SLT, others reserved)
//   a, b     : 32-bit operands, captured when a request is accepted
//   busy     : sequencer is not idle
//   done     : one-cycle completion pulse
//   result   : 32-bit result, held until the next completion
//   zero     : result == 0
//   overflow : signed overflow for ADD/SUB
interface alu_serial_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero, overflow
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero, overflow
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial 32-bit ALU sequencer. A single 1-bit slice is stepped over bit
// positions 0..31, one per clock, with the inter-bit carry kept in a flop.
// SLT takes one extra fix-up cycle to turn the subtraction into a 0/1 result.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_serial_if.slave (start/op/a/b in; busy/done/result/zero/overflow out)
//
// state   | meaning
// IDLE    | waiting for start; operands latched on accept
// RUN     | one bit per cycle, cnt = bit being processed
// SLT_FIX | result = sign of (a-b) corrected by overflow
// DONE    | done pulse, result/flags valid
module alu_serial_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  alu_serial_if.slave  bus
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, SLT_FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        carry;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q;
  logic [31:0] result_sr;
  logic        ovf_q;
  logic [31:0] result_q;
  logic        zero_q;
  logic        overflow_q;

  logic        x, y, c_out, slice, ovf_now, last_bit, op_valid, op_arith, slt_set;
  logic [31:0] sr_nxt, res_run;

  // one slice of the ALU, operating on the current bit position
  always_comb begin
    x       = a_q[cnt];
    y       = b_q[cnt] ^ op_q[2];
    c_out   = (x & y) | (carry & (x ^ y));
    case (op_q)
      OP_AND:  slice = x & y;
      OP_OR:   slice = x | y;
      default: slice = x ^ y ^ carry;
    endcase
    // shift in at the top so bit 0 lands at [0] after 32 shifts
    sr_nxt   = {slice, result_sr[31:1]};
    ovf_now  = carry ^ c_out;
    last_bit = (state == RUN) && (cnt == 5'd31);
    op_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    op_valid = op_arith || (op_q == OP_AND) || (op_q == OP_OR);
    res_run  = op_valid ? sr_nxt : 32'h0;
    slt_set  = result_sr[31] ^ ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b1;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == 5'd31) state_nxt = (op_q == OP_SLT) ? SLT_FIX : DONE;
      end
      SLT_FIX: state_nxt = DONE;
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 5'd0;
      carry      <= 1'b0;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      op_q       <= 3'b000;
      result_sr  <= 32'h0;
      ovf_q      <= 1'b0;
      result_q   <= 32'h0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            op_q  <= bus.op;
            cnt   <= 5'd0;
            carry <= bus.op[2];
          end
        end
        RUN: begin
          result_sr <= sr_nxt;
          carry     <= c_out;
          cnt       <= cnt + 5'd1;
          if (last_bit) begin
            ovf_q <= ovf_now;
            // SLT publishes its result from SLT_FIX instead
            if (op_q != OP_SLT) begin
              result_q   <= res_run;
              zero_q     <= (res_run == 32'h0);
              overflow_q <= op_arith & ovf_now;
            end
          end
        end
        SLT_FIX: begin
          result_q   <= {31'b0, slt_set};
          zero_q     <= ~slt_set;
          overflow_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = overflow_q;

endmodule
